// File: rtl/cmd_uart_tx.sv
// cmd_uart_tx
//   Serializes 32-bit command/response words onto a UART 8N1 line.
//   Each accepted word goes out as 4 bytes, MSB byte first.
//   Each byte is sent LSB first, framed by one start bit and STOP_BITS stop bits.
//   The block has its own baud divider, so no external uart instance is needed.
//
// Ports
//   clk                sole clock
//   reset_i            asynchronous active-high reset
//   cmd_axis_tvalid_i  word valid from the producer
//   cmd_axis_tready_o  high only while idle; the word is taken on tvalid && tready
//   cmd_axis_tdata_i   word to send; [31:24] goes out first
//   tx_o               registered UART serial output, idle high
//   busy_o             a word is in flight
//
// Parameters
//   FREQ_MHZ, BAUD_RATE  give CLKS_PER_BIT = FREQ_MHZ*1e6/BAUD_RATE (must be >= 2)
//   STOP_BITS            1 or 2 stop bits per byte

module cmd_uart_tx #(
  parameter int FREQ_MHZ  = 25,
  parameter int BAUD_RATE = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        cmd_axis_tvalid_i,
  output logic        cmd_axis_tready_o,
  input  logic [31:0] cmd_axis_tdata_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int CLKS_PER_BIT = (FREQ_MHZ * 1000000) / BAUD_RATE;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  // The counter must reach the longest phase, which is the stop period.
  localparam int CNT_W        = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_n;
  logic [31:0]       holding, holding_n;
  logic              tx_q, tx_n;
  logic [7:0]        cur_byte;
  logic [2:0]        next_bit;
  logic              handshake;

  // Ready comes only from the registered state. It is also forced low while reset is held.
  assign cmd_axis_tready_o = (state == IDLE) && !reset_i;
  assign busy_o            = (state != IDLE);
  assign tx_o              = tx_q;
  assign handshake         = cmd_axis_tvalid_i && cmd_axis_tready_o;
  assign next_bit          = bit_cnt + 3'd1;

  // Select the byte currently on the wire: index 0 is the most significant byte.
  always_comb begin
    cur_byte = holding[31:24];
    case (byte_idx)
      2'd0:    cur_byte = holding[31:24];
      2'd1:    cur_byte = holding[23:16];
      2'd2:    cur_byte = holding[15:8];
      default: cur_byte = holding[7:0];
    endcase
  end

  // Next-state logic.
  // tx_n is the line level for the next cycle, so tx_o can stay a plain flop.
  // Each phase counts 0..last and then reloads to zero, so bit periods are exact and never drift.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    bit_cnt_n  = bit_cnt;
    baud_cnt_n = baud_cnt;
    holding_n  = holding;
    tx_n       = tx_q;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (handshake) begin
          holding_n  = cmd_axis_tdata_i;
          state_n    = START;
          byte_idx_n = 2'd0;
          bit_cnt_n  = 3'd0;
          baud_cnt_n = '0;
          tx_n       = 1'b0;
        end
      end

      START: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_n = '0;
          bit_cnt_n  = 3'd0;
          state_n    = DATA;
          tx_n       = cur_byte[0];
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = next_bit;
            tx_n      = cur_byte[next_bit];
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        tx_n = 1'b1;
        if (baud_cnt == STOP_LAST) begin
          baud_cnt_n = '0;
          if (byte_idx == 2'd3) begin
            state_n = IDLE;
          end else begin
            // The next start bit follows straight on, with no idle gap.
            byte_idx_n = byte_idx + 2'd1;
            state_n    = START;
            tx_n       = 1'b0;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // State register.
  // Reset drives the line high at once and drops any partial word.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      byte_idx <= 2'd0;
      bit_cnt  <= 3'd0;
      baud_cnt <= '0;
      holding  <= 32'd0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      byte_idx <= byte_idx_n;
      bit_cnt  <= bit_cnt_n;
      baud_cnt <= baud_cnt_n;
      holding  <= holding_n;
      tx_q     <= tx_n;
    end
  end

endmodule
